video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Raster timing generator feeding the DVI/HDMI transmitter top (pclk domain).
//  Produces hsync/vsync/de plus 24-bit RGB, aligned to the transmitter's video inputs.
//  Requests pixels from an upstream painter (e.g. block-move display) via xpos/ypos + pixel_req.
//  Default timing is 1280x720@60 (74.25 MHz pclk).
// PARAMETERS
//  H_SYNC   40    hsync width, pclk cycles
//  H_BACK   220   horizontal back porch
//  H_DISP   1280  active pixels per line
//  H_FRONT  110   horizontal front porch
//  V_SYNC   5     vsync width, lines
//  V_BACK   20    vertical back porch
//  V_DISP   720   active lines
//  V_FRONT  5     vertical front porch
//  HS_POL   1     active level of video_hs (1 = active-high)
//  VS_POL   1     active level of video_vs
//  Derived (localparam): H_TOTAL = sum of H_* (1650); V_TOTAL = sum of V_* (750).
// PORTS
//  pclk         in   1   pixel clock
//  reset_n      in   1   async active-low reset
//  pixel_data   in   24  RGB888 from upstream, valid the cycle after pixel_req
//  pixel_req    out  1   pixel request for (pixel_xpos, pixel_ypos)
//  pixel_xpos   out  12  active-area column, 0..H_DISP-1
//  pixel_ypos   out  12  active-area row, 0..V_DISP-1
//  frame_start  out  1   one-cycle pulse at start of each frame
//  video_hs     out  1   hsync to transmitter
//  video_vs     out  1   vsync to transmitter
//  video_de     out  1   data enable to transmitter
//  video_rgb    out  24  RGB888 to transmitter ({R,G,B})
// BEHAVIOUR
//  - Counters: h_cnt 0..H_TOTAL-1, wraps to 0. v_cnt increments on the h_cnt wrap,
//    range 0..V_TOTAL-1, wraps to 0. Region order per axis: sync, back, active, front.
//  - hs_int = (h_cnt < H_SYNC); vs_int = (v_cnt < V_SYNC).
//  - de_int = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) AND v_cnt in same V window.
//  - Stage 1 (registered from counters):
//      pixel_req <= de_int
//      pixel_xpos/pixel_ypos <= h_cnt-(H_SYNC+H_BACK), v_cnt-(V_SYNC+V_BACK) when de_int, else 0
//      frame_start <= (h_cnt==0 && v_cnt==0)
//  - Upstream returns pixel_data exactly one cycle after pixel_req (registered source).
//  - Stage 2 (registered): video_hs/vs = stage-1 sync XNOR HS_POL/VS_POL;
//    video_de = pixel_req delayed 1; video_rgb = that de ? pixel_data : 24'h0.
//  - Latency: counter -> video_* = 2 pclk; hs, vs, de, rgb mutually aligned.
//  - Sync and DE alignment is never skewed by pixel_data content.
//  - frame_start leads the frame's first video_hs assertion by 1 pclk.
//  - Reset (async assert, sync release by caller's synchroniser): h_cnt=v_cnt=0;
//    pixel_req=0, pixel_xpos/pixel_ypos=0, frame_start=0, video_de=0, video_rgb=0,
//    video_hs=~HS_POL, video_vs=~VS_POL.
//  - Reset mid-frame: all state discarded; first cycle after release is h=0,v=0.
//    frame_start pulses 1 cycle later; no partial line is emitted.
//  - Arithmetic: counters 12-bit unsigned; H_TOTAL, V_TOTAL must be <= 4096
//    (compile-time check in simulation).
// STRUCTURE
//  - Shared include video_timing_defs.vh: timing parameter sets for 480p/720p/1080p.
//  - Single module, no sub-modules; two counters + two register stages.
// TESTING
//  1 Reset held 10 cycles, defaults -> video_hs=0, video_de=0, video_rgb=0, pixel_req=0.
//  2 Defaults, run 2 frames -> hs low-high pattern 40/1610 per 1650 cycles;
//    de high 1280/line on 720 lines; frame_start period 1237500.
//  3 Small params H 2/2/4/2, V 1/1/3/1, registered echo pixel_data={ypos,xpos} ->
//    video_rgb sequence 0x000000..0x000003 on row 0; video_de coincides; rgb=0 outside de.
//  4 Alignment: pixel_req first high at h_cnt=261 (defaults, after counter-to-stage-1
//    register) -> video_de first high 1 cycle later; xpos=0, ypos=0 on that request.
//  5 HS_POL=0, VS_POL=0 -> video_hs low only 40 cycles/line; video_vs low 5 lines; reset idle high.
//  6 Assert reset_n low mid-line (h=700, v=300) for 3 cycles -> outputs to reset values async.
//    After release, frame_start after 1 cycle; de_int first at h=260, v=25.

Source files
------------

// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
//   Shared types and timing sets for the raster timing generator.
//   Holds the counter width, the per-axis timing record, standard timing
//   sets (480p, 720p, 1080p) and small helpers used by video_timing_gen.
//   No ports; imported with `import video_timing_pkg::*;`.
// ---------------------------------------------------------------------------
package video_timing_pkg;

   localparam int CNT_W   = 12;            // h/v counter width
   localparam int CNT_MAX = 1 << CNT_W;    // largest legal H_TOTAL / V_TOTAL
   localparam int RGB_W   = 24;            // RGB888

   // One axis: region lengths in the order they are scanned.
   typedef struct packed {
      int unsigned sync;
      int unsigned back;
      int unsigned disp;
      int unsigned front;
   } axis_timing_t;

   typedef struct packed {
      axis_timing_t h;
      axis_timing_t v;
      logic         hs_pol;
      logic         vs_pol;
   } video_timing_t;

   // 640x480@60, 25.175 MHz, negative syncs
   localparam video_timing_t TIMING_480P = '{
      h: '{96, 48, 640, 16}, v: '{2, 33, 480, 10}, hs_pol: 1'b0, vs_pol: 1'b0};
   // 1280x720@60, 74.25 MHz, positive syncs
   localparam video_timing_t TIMING_720P = '{
      h: '{40, 220, 1280, 110}, v: '{5, 20, 720, 5}, hs_pol: 1'b1, vs_pol: 1'b1};
   // 1920x1080@60, 148.5 MHz, positive syncs
   localparam video_timing_t TIMING_1080P = '{
      h: '{44, 148, 1920, 88}, v: '{5, 36, 1080, 4}, hs_pol: 1'b1, vs_pol: 1'b1};

   function automatic int unsigned axis_total(input axis_timing_t a);
      return a.sync + a.back + a.disp + a.front;
   endfunction

   // Half-open window test; one extra bit so an upper bound of CNT_MAX fits.
   function automatic logic in_window(input logic [CNT_W:0] cnt,
                                      input logic [CNT_W:0] lo,
                                      input logic [CNT_W:0] hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator for the DVI/HDMI transmitter (pclk domain).
//   Two free-running counters scan sync/back/active/front on each axis; a
//   first register stage issues pixel requests with active-area coordinates,
//   a second stage aligns sync, data enable and the returned RGB.
//
// Ports
//   pclk         in   pixel clock
//   reset_n      in   async active-low reset (release synchronised by caller)
//   pixel_data   in   RGB888 from upstream, answering the current pixel_req
//   pixel_req    out  pixel request for (pixel_xpos, pixel_ypos)
//   pixel_xpos   out  active-area column, 0..H_DISP-1 (0 when idle)
//   pixel_ypos   out  active-area row,    0..V_DISP-1 (0 when idle)
//   frame_start  out  one-cycle pulse at the start of each frame
//   video_hs     out  hsync, active level HS_POL
//   video_vs     out  vsync, active level VS_POL
//   video_de     out  data enable
//   video_rgb    out  {R,G,B}, zero outside data enable
// ---------------------------------------------------------------------------
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_SYNC  = int'(TIMING_720P.h.sync),
   parameter int H_BACK  = int'(TIMING_720P.h.back),
   parameter int H_DISP  = int'(TIMING_720P.h.disp),
   parameter int H_FRONT = int'(TIMING_720P.h.front),
   parameter int V_SYNC  = int'(TIMING_720P.v.sync),
   parameter int V_BACK  = int'(TIMING_720P.v.back),
   parameter int V_DISP  = int'(TIMING_720P.v.disp),
   parameter int V_FRONT = int'(TIMING_720P.v.front),
   parameter bit HS_POL  = 1'b1,
   parameter bit VS_POL  = 1'b1
) (
   input  logic             pclk,
   input  logic             reset_n,
   input  logic [RGB_W-1:0] pixel_data,
   output logic             pixel_req,
   output logic [CNT_W-1:0] pixel_xpos,
   output logic [CNT_W-1:0] pixel_ypos,
   output logic             frame_start,
   output logic             video_hs,
   output logic             video_vs,
   output logic             video_de,
   output logic [RGB_W-1:0] video_rgb
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

   // Counter-width constants; window bounds carry one extra bit so a
   // total of exactly CNT_MAX does not wrap the active upper bound.
   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_ACT_OFS = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] V_ACT_OFS = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W:0]   H_ACT_LO  = (CNT_W+1)'(H_SYNC + H_BACK);
   localparam logic [CNT_W:0]   H_ACT_HI  = (CNT_W+1)'(H_SYNC + H_BACK + H_DISP);
   localparam logic [CNT_W:0]   V_ACT_LO  = (CNT_W+1)'(V_SYNC + V_BACK);
   localparam logic [CNT_W:0]   V_ACT_HI  = (CNT_W+1)'(V_SYNC + V_BACK + V_DISP);

   // Elaboration-time guard: counters are CNT_W bits.
   if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
   end
   if (H_SYNC < 1 || H_DISP < 1 || V_SYNC < 1 || V_DISP < 1) begin : g_bad_region
      $error("video_timing_gen: sync and display regions must be non-empty");
   end

   // ------------------------------------------------------------------
   // Raster counters
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_last;
   logic             v_last;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Region decode from the raw counters
   // ------------------------------------------------------------------
   logic hs_int;
   logic vs_int;
   logic h_act;
   logic v_act;
   logic de_int;
   logic frame_origin;

   assign hs_int       = (h_cnt < H_SYNC_C);
   assign vs_int       = (v_cnt < V_SYNC_C);
   assign h_act        = in_window({1'b0, h_cnt}, H_ACT_LO, H_ACT_HI);
   assign v_act        = in_window({1'b0, v_cnt}, V_ACT_LO, V_ACT_HI);
   assign de_int       = h_act && v_act;
   assign frame_origin = (h_cnt == '0) && (v_cnt == '0);

   // ------------------------------------------------------------------
   // Stage 1: request to upstream; syncs travel alongside as active-high
   // flags so polarity is applied once, at the output register.
   // ------------------------------------------------------------------
   logic hs_s1;
   logic vs_s1;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         pixel_req   <= 1'b0;
         pixel_xpos  <= '0;
         pixel_ypos  <= '0;
         frame_start <= 1'b0;
         hs_s1       <= 1'b0;
         vs_s1       <= 1'b0;
      end else begin
         pixel_req   <= de_int;
         pixel_xpos  <= de_int ? h_cnt - H_ACT_OFS : '0;
         pixel_ypos  <= de_int ? v_cnt - V_ACT_OFS : '0;
         frame_start <= frame_origin;
         hs_s1       <= hs_int;
         vs_s1       <= vs_int;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: transmitter-facing outputs. pixel_data answers the request
   // held in stage 1, so it is captured on the same edge that moves the
   // request into video_de. Sync/DE never depend on pixel_data.
   // ------------------------------------------------------------------
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         video_hs  <= ~HS_POL;
         video_vs  <= ~VS_POL;
         video_de  <= 1'b0;
         video_rgb <= '0;
      end else begin
         video_hs  <= hs_s1 ~^ HS_POL;
         video_vs  <= vs_s1 ~^ VS_POL;
         video_de  <= pixel_req;
         video_rgb <= pixel_req ? pixel_data : '0;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Three instances: A at default 720p timing, B and C at a tiny raster
//   (H 2/2/4/2, V 1/1/3/1) with positive and negative sync polarity.
//   A reference model derives every output from the edge count since reset
//   release; a negedge process compares all outputs each cycle, and upstream
//   echoes {ypos,xpos} (garbage when no request) back as pixel_data.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

   typedef struct packed {
      int hs, hb, hd, hf, vs, vb, vd, vf;
      bit hp, vp;
   } tcfg_t;

   typedef struct packed {
      logic        req;
      logic [11:0] xp;
      logic [11:0] yp;
      logic        fs, hs, vs, de;
      logic [23:0] rgb;
   } obs_t;

   localparam tcfg_t CFG_A = '{40, 220, 1280, 110, 5, 20, 720, 5, 1'b1, 1'b1};
   localparam tcfg_t CFG_B = '{2, 2, 4, 2, 1, 1, 3, 1, 1'b1, 1'b1};
   localparam tcfg_t CFG_C = '{2, 2, 4, 2, 1, 1, 3, 1, 1'b0, 1'b0};

   logic pclk  = 1'b0;
   logic rst_a = 1'b0;
   logic rst_s = 1'b0;
   logic [23:0] pd_a = '0, pd_b = '0, pd_c = '0;

   logic req_a, fs_a, hs_a, vs_a, de_a; logic [11:0] xp_a, yp_a; logic [23:0] rgb_a;
   logic req_b, fs_b, hs_b, vs_b, de_b; logic [11:0] xp_b, yp_b; logic [23:0] rgb_b;
   logic req_c, fs_c, hs_c, vs_c, de_c; logic [11:0] xp_c, yp_c; logic [23:0] rgb_c;
   obs_t obs_a, obs_b, obs_c;

   assign obs_a = {req_a, xp_a, yp_a, fs_a, hs_a, vs_a, de_a, rgb_a};
   assign obs_b = {req_b, xp_b, yp_b, fs_b, hs_b, vs_b, de_b, rgb_b};
   assign obs_c = {req_c, xp_c, yp_c, fs_c, hs_c, vs_c, de_c, rgb_c};

   always #5 pclk = ~pclk;

   video_timing_gen u_a (
      .pclk(pclk), .reset_n(rst_a), .pixel_data(pd_a), .pixel_req(req_a),
      .pixel_xpos(xp_a), .pixel_ypos(yp_a), .frame_start(fs_a),
      .video_hs(hs_a), .video_vs(vs_a), .video_de(de_a), .video_rgb(rgb_a));

   video_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
                      .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
                      .HS_POL(1'b1), .VS_POL(1'b1)) u_b (
      .pclk(pclk), .reset_n(rst_s), .pixel_data(pd_b), .pixel_req(req_b),
      .pixel_xpos(xp_b), .pixel_ypos(yp_b), .frame_start(fs_b),
      .video_hs(hs_b), .video_vs(vs_b), .video_de(de_b), .video_rgb(rgb_b));

   video_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
                      .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
                      .HS_POL(1'b0), .VS_POL(1'b0)) u_c (
      .pclk(pclk), .reset_n(rst_s), .pixel_data(pd_c), .pixel_req(req_c),
      .pixel_xpos(xp_c), .pixel_ypos(yp_c), .frame_start(fs_c),
      .video_hs(hs_c), .video_vs(vs_c), .video_de(de_c), .video_rgb(rgb_c));

   int vectors = 0;
   int miscompares = 0;
   int n_a = 0;     // rising edges since A left reset
   int n_s = 0;     // rising edges since B/C left reset

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Outputs after n edges: stage 1 shows raster position n-1, stage 2
   // shows n-2; anything earlier is the reset value.
   function automatic obs_t model(input tcfg_t c, input int n);
      obs_t e;
      int ht, vt, k, h, v;
      logic act;
      ht = c.hs + c.hb + c.hd + c.hf;
      vt = c.vs + c.vb + c.vd + c.vf;
      e = '0;
      e.hs = !c.hp;
      e.vs = !c.vp;
      if (n >= 1) begin
         k = n - 1; h = k % ht; v = (k / ht) % vt;
         act = (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.hd) &&
               (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.vd);
         e.req = act;
         if (act) begin
            e.xp = 12'(h - c.hs - c.hb);
            e.yp = 12'(v - c.vs - c.vb);
         end
         e.fs = (h == 0) && (v == 0);
      end
      if (n >= 2) begin
         k = n - 2; h = k % ht; v = (k / ht) % vt;
         act = (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.hd) &&
               (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.vd);
         e.hs  = (h < c.hs) ? c.hp : !c.hp;
         e.vs  = (v < c.vs) ? c.vp : !c.vp;
         e.de  = act;
         e.rgb = act ? {12'(v - c.vs - c.vb), 12'(h - c.hs - c.hb)} : 24'h0;
      end
      return e;
   endfunction

   task automatic cmp_obs(input string name, input tcfg_t c, input int n, input obs_t o);
      obs_t e;
      e = model(c, n);
      chk({name, ".req"}, 32'(o.req), 32'(e.req));
      chk({name, ".xpos"}, 32'(o.xp), 32'(e.xp));
      chk({name, ".ypos"}, 32'(o.yp), 32'(e.yp));
      chk({name, ".frame_start"}, 32'(o.fs), 32'(e.fs));
      chk({name, ".hs"}, 32'(o.hs), 32'(e.hs));
      chk({name, ".vs"}, 32'(o.vs), 32'(e.vs));
      chk({name, ".de"}, 32'(o.de), 32'(e.de));
      chk({name, ".rgb"}, 32'(o.rgb), 32'(e.rgb));
   endtask

   // Monitor state for hand-computed pins
   int first_req_a = -1, first_de_a = -1;
   logic [23:0] first_req_pos_a = '1;
   logic [23:0] rgb_q[$];
   bit armed = 1'b0;
   int last_fs = 0;
   int hs_b_cnt, vs_b_cnt, de_b_cnt, hs_c_low, vs_c_low;

   always @(negedge pclk) begin
      if (!rst_a) n_a = 0; else n_a++;
      if (!rst_s) n_s = 0; else n_s++;
      cmp_obs("A", CFG_A, n_a, obs_a);
      cmp_obs("B", CFG_B, n_s, obs_b);
      cmp_obs("C", CFG_C, n_s, obs_c);

      if (rst_a && req_a && first_req_a < 0) begin
         first_req_a = n_a;
         first_req_pos_a = {yp_a, xp_a};
      end
      if (rst_a && de_a && first_de_a < 0) first_de_a = n_a;
      if (de_b && rgb_q.size() < 5) rgb_q.push_back(rgb_b);

      // Per-frame totals on the small raster: 6 lines of 10 cycles.
      if (!rst_s) armed = 1'b0;
      else begin
         if (fs_b) begin
            if (armed) begin
               chk("B.fs_period", 32'(n_s - last_fs), 32'd60);
               chk("B.hs_high_per_frame", 32'(hs_b_cnt), 32'd12);
               chk("B.vs_high_per_frame", 32'(vs_b_cnt), 32'd10);
               chk("B.de_high_per_frame", 32'(de_b_cnt), 32'd12);
               chk("C.hs_low_per_frame", 32'(hs_c_low), 32'd12);
               chk("C.vs_low_per_frame", 32'(vs_c_low), 32'd10);
            end
            armed = 1'b1;
            last_fs = n_s;
            hs_b_cnt = 0; vs_b_cnt = 0; de_b_cnt = 0; hs_c_low = 0; vs_c_low = 0;
         end
         hs_b_cnt += int'(hs_b);
         vs_b_cnt += int'(vs_b);
         de_b_cnt += int'(de_b);
         hs_c_low += int'(!hs_c);
         vs_c_low += int'(!vs_c);
      end

      // Registered-style echo: valid only while a request is outstanding.
      pd_a = req_a ? {yp_a, xp_a} : 24'hA5A5A5;
      pd_b = req_b ? {yp_b, xp_b} : 24'hA5A5A5;
      pd_c = req_c ? {yp_c, xp_c} : 24'hA5A5A5;
   end

   task automatic wait_a(input int target, input int budget);
      for (int i = 0; i < budget && n_a != target; i++) begin
         @(negedge pclk); #1;
      end
      chk("wait_a_reached", 32'(n_a), 32'(target));
   endtask

   task automatic wait_s(input int target, input int budget);
      for (int i = 0; i < budget && n_s != target; i++) begin
         @(negedge pclk); #1;
      end
      chk("wait_s_reached", 32'(n_s), 32'(target));
   endtask

   initial begin
      repeat (10) @(negedge pclk);
      #1;
      chk("rst.A.hs", 32'(hs_a), 32'd0);
      chk("rst.A.de", 32'(de_a), 32'd0);
      chk("rst.A.rgb", 32'(rgb_a), 32'd0);
      chk("rst.A.req", 32'(req_a), 32'd0);
      chk("rst.C.hs", 32'(hs_c), 32'd1);
      chk("rst.C.vs", 32'(vs_c), 32'd1);
      rst_a = 1'b1;
      rst_s = 1'b1;

      // Small raster: first row echoes 0..3, next row starts at {1,0}.
      wait_s(207, 400);
      chk("B.row_len", 32'(rgb_q.size()), 32'd5);
      if (rgb_q.size() == 5) begin
         chk("B.rgb0", 32'(rgb_q[0]), 32'h000000);
         chk("B.rgb1", 32'(rgb_q[1]), 32'h000001);
         chk("B.rgb2", 32'(rgb_q[2]), 32'h000002);
         chk("B.rgb3", 32'(rgb_q[3]), 32'h000003);
         chk("B.rgb4", 32'(rgb_q[4]), 32'h001000);
      end
      // Mid-line (h=7, v=2): video is on pixel (1,0); reset must clear it async.
      chk("B.pre_rst_de", 32'(de_b), 32'd1);
      chk("B.pre_rst_rgb", 32'(rgb_b), 32'h000001);
      @(posedge pclk); #2;
      rst_s = 1'b0;
      #1;
      chk("B.async_req", 32'(req_b), 32'd0);
      chk("B.async_de", 32'(de_b), 32'd0);
      chk("B.async_rgb", 32'(rgb_b), 32'd0);
      chk("B.async_xpos", 32'(xp_b), 32'd0);
      chk("C.async_hs", 32'(hs_c), 32'd1);
      repeat (3) @(negedge pclk);
      #1;
      rst_s = 1'b1;
      wait_s(1, 10);
      chk("B.fs_after_release", 32'(fs_b), 32'd1);
      wait_s(24, 40);
      chk("B.req_before_active", 32'(req_b), 32'd0);
      wait_s(25, 10);
      chk("B.req_first_active", 32'(req_b), 32'd1);

      // Default timing: first request from h=260, v=25.
      wait_a(41512, 50000);
      chk("A.first_req_edge", 32'(first_req_a), 32'd41511);
      chk("A.first_de_edge", 32'(first_de_a), 32'd41512);
      chk("A.first_req_pos", 32'(first_req_pos_a), 32'h000000);

      // Mid-line reset at h=700, v=25 while video is active.
      wait_a(41950, 1000);
      chk("A.pre_rst_de", 32'(de_a), 32'd1);
      rst_a = 1'b0;
      #1;
      chk("A.async_de", 32'(de_a), 32'd0);
      chk("A.async_rgb", 32'(rgb_a), 32'd0);
      chk("A.async_req", 32'(req_a), 32'd0);
      chk("A.async_hs", 32'(hs_a), 32'd0);
      chk("A.async_ypos", 32'(yp_a), 32'd0);
      repeat (3) @(negedge pclk);
      #1;
      rst_a = 1'b1;
      wait_a(1, 10);
      chk("A.fs_after_release", 32'(fs_a), 32'd1);
      chk("A.hs_before_fs_lead", 32'(hs_a), 32'd0);
      wait_a(2, 10);
      chk("A.hs_after_fs", 32'(hs_a), 32'd1);
      repeat (50) @(negedge pclk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
